// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the RF command-frame controller.
// One-hot parser states, default header bytes and statistics counter helpers.
package rf_ctrl_pkg;

    localparam int unsigned CNT_W = 8;

    localparam logic [7:0] HEAD0_DEF = 8'h55;
    localparam logic [7:0] HEAD1_DEF = 8'hAA;

    typedef enum logic [6:0] {
        S_IDLE  = 7'b000_0001,
        S_HEAD  = 7'b000_0010,
        S_ADDR  = 7'b000_0100,
        S_LEN   = 7'b000_1000,
        S_DATA  = 7'b001_0000,
        S_CSUM  = 7'b010_0000,
        S_WRITE = 7'b100_0000
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rf_frame_buf.sv
// Payload buffer: DEPTH x 8 register file, one synchronous write port, one async read port.
// Write takes effect next cycle; read is combinational; no backpressure (caller owns indexing).
module rf_frame_buf #(
    parameter int unsigned DEPTH = 16
) (
    input  logic       clk,
    input  logic       we_i,
    input  logic [7:0] wr_idx_i,
    input  logic [7:0] wr_dat_i,
    input  logic [7:0] rd_idx_i,
    output logic [7:0] rd_dat_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (wr_idx_i == 8'(i)) begin
                    mem_q[i] <= wr_dat_i;
                end
            end
        end
    end

    // Out-of-range reads (one past the last item) return zero; that value is never used.
    always_comb begin
        rd_dat_o = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (rd_idx_i == 8'(i)) begin
                rd_dat_o = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/rf_frame_ctrl.sv
// Parses HEAD0 HEAD1 ADDR LEN DATA.. CSUM frames, then replays the payload as register writes.
// First write the cycle after CSUM; writes hold under !i_wr_rdy; bytes arriving mid-write are dropped.
module rf_frame_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned TIMEOUT_CYC = 52080,
    parameter logic [7:0]  HEAD0       = HEAD0_DEF,
    parameter logic [7:0]  HEAD1       = HEAD1_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_data_vld,
    output logic             o_wr_en,
    output logic [7:0]       o_wr_addr,
    output logic [7:0]       o_wr_data,
    input  logic             i_wr_rdy,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_frm_ok_cnt,
    output logic [CNT_W-1:0] o_frm_err_cnt,
    output logic [CNT_W-1:0] o_drop_cnt
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

    state_e           state_q, state_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       idx_q, idx_d;
    logic [7:0]       sum_q, sum_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             wr_en_q, wr_en_d;
    logic [7:0]       wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] ok_q, ok_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic             buf_we;
    logic [7:0]       buf_rd_idx;
    logic [7:0]       buf_rd_dat;

    // In CSUM the read port fetches item 0; in WRITE it prefetches the item after the one on the bus.
    assign buf_rd_idx = (state_q == S_WRITE) ? idx_q + 8'd1 : 8'd0;

    rf_frame_buf #(
        .DEPTH (MAX_LEN)
    ) u_buf (
        .clk      (clk),
        .we_i     (buf_we),
        .wr_idx_i (idx_q),
        .wr_dat_i (i_rx_data),
        .rd_idx_i (buf_rd_idx),
        .rd_dat_o (buf_rd_dat)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        tmo_d     = '0;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        ok_d      = ok_q;
        err_d     = err_q;
        drop_d    = drop_q;
        buf_we    = 1'b0;

        if (state_q == S_WRITE) begin
            if (i_rx_data_vld) begin
                drop_d = sat_inc(drop_q);
            end
            if (i_wr_rdy) begin
                if (idx_q == len_q - 8'd1) begin
                    wr_en_d = 1'b0;
                    ok_d    = sat_inc(ok_q);
                    state_d = S_IDLE;
                end else begin
                    idx_d     = idx_q + 8'd1;
                    wr_addr_d = wr_addr_q + 8'd1;
                    wr_data_d = buf_rd_dat;
                end
            end
        end else if (i_rx_data_vld) begin
            case (state_q)
                S_IDLE: begin
                    if (i_rx_data == HEAD0) begin
                        state_d = S_HEAD;
                    end
                end
                S_HEAD: begin
                    if (i_rx_data == HEAD1) begin
                        state_d = S_ADDR;
                        sum_d   = '0;
                    end else if (i_rx_data != HEAD0) begin
                        state_d = S_IDLE;
                    end
                end
                S_ADDR: begin
                    addr_d  = i_rx_data;
                    sum_d   = sum_q + i_rx_data;
                    state_d = S_LEN;
                end
                S_LEN: begin
                    sum_d = sum_q + i_rx_data;
                    if (i_rx_data == 8'd0 || i_rx_data > MAX_LEN_B) begin
                        err_d   = sat_inc(err_q);
                        state_d = S_IDLE;
                    end else begin
                        len_d   = i_rx_data;
                        idx_d   = '0;
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    buf_we = 1'b1;
                    sum_d  = sum_q + i_rx_data;
                    if (idx_q == len_q - 8'd1) begin
                        state_d = S_CSUM;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
                S_CSUM: begin
                    if (i_rx_data == sum_q) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = buf_rd_dat;
                        idx_d     = '0;
                        state_d   = S_WRITE;
                    end else begin
                        err_d   = sat_inc(err_q);
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            // Mid-frame silence: an arriving byte always takes priority over expiry.
            if (tmo_q == TMO_LAST) begin
                err_d   = sat_inc(err_q);
                state_d = S_IDLE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            sum_q     <= '0;
            tmo_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            ok_q      <= '0;
            err_q     <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            tmo_q     <= tmo_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
            drop_q    <= drop_d;
        end
    end

    assign o_wr_en       = wr_en_q;
    assign o_wr_addr     = wr_addr_q;
    assign o_wr_data     = wr_data_q;
    assign o_busy        = busy_q;
    assign o_frm_ok_cnt  = ok_q;
    assign o_frm_err_cnt = err_q;
    assign o_drop_cnt    = drop_q;

endmodule
